// File: rtl/branch_resolve_unit.sv
// Branch resolution for the RV32I EX stage: outcome/target decision, mispredict
// redirect, bimodal branch history table for IF, and branch statistics.
module branch_resolve_unit #(
    parameter int BHT_IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_br,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic        br_en,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int BHT_N = 1 << BHT_IDX_BITS;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [1:0]              bht_q [BHT_N];
    logic [1:0]              bht_d [BHT_N];
    logic                    redirect_valid_q, redirect_valid_d;
    logic [31:0]             redirect_pc_q, redirect_pc_d;
    logic                    misalign_q, misalign_d;
    logic [31:0]             branch_count_q, branch_count_d;
    logic [31:0]             mispredict_count_q, mispredict_count_d;

    logic                    is_jump;
    logic                    resolve;
    logic                    taken;
    logic                    mispredict;
    logic [31:0]             tgt;
    logic [31:0]             actual;
    logic [BHT_IDX_BITS-1:0] ex_idx;
    logic [BHT_IDX_BITS-1:0] if_idx;
    logic                    unused_pc_bits;

    assign ex_idx = ex_pc[BHT_IDX_BITS+1:2];
    assign if_idx = if_pc[BHT_IDX_BITS+1:2];
    assign unused_pc_bits = ^{if_pc[31:BHT_IDX_BITS+2], if_pc[1:0]};

    // Old counter value is seen by IF even when EX writes the same entry this cycle.
    assign if_pred_taken = bht_q[if_idx][1];

    always_comb begin
        is_jump    = ex_is_jal | ex_is_jalr;
        // The instruction in EX right after a redirect is wrong-path and must be ignored.
        resolve    = ex_valid & ~ex_stall & (ex_is_br | is_jump) & ~redirect_valid_q;
        taken      = is_jump ? 1'b1 : br_en;
        tgt        = {ex_target[31:1], ex_target[0] & ~ex_is_jalr};
        actual     = taken ? tgt : ex_pc + 32'd4;
        mispredict = (taken != ex_pred_taken) |
                     (taken & ex_pred_taken & (tgt != ex_pred_target));
    end

    always_comb begin
        bht_d              = bht_q;
        redirect_valid_d   = resolve & mispredict;
        redirect_pc_d      = redirect_pc_q;
        misalign_d         = resolve & taken & (tgt[1:0] != 2'b00);
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (resolve) begin
            branch_count_d = branch_count_q + 32'd1;
            if (mispredict) begin
                redirect_pc_d      = actual;
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
            if (ex_is_br && !is_jump) begin
                bht_d[ex_idx] = br_en ? sat_inc(bht_q[ex_idx]) : sat_dec(bht_q[ex_idx]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= 32'd0;
            misalign_q         <= 1'b0;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            bht_q              <= bht_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            misalign_q         <= misalign_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign flush            = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign misalign         = misalign_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a behavioural model predicts each
// cycle's registered outputs, which are queued at drive time and checked after the edge.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_stall, ex_is_br, ex_is_jal, ex_is_jalr, br_en, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target, if_pc;
    logic        if_pred_taken, redirect_valid, flush, misalign;
    logic [31:0] redirect_pc, branch_count, mispredict_count;

    branch_resolve_unit #(.BHT_IDX_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
        .ex_is_br(ex_is_br), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .br_en(br_en), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .misalign(misalign), .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [1:0]  m_bht [64];
    logic        m_rv;
    logic [31:0] m_pc, m_bc, m_mc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_rv = 1'b0;
        m_pc = 32'd0;
        m_bc = 32'd0;
        m_mc = 32'd0;
        sb_q.delete();
    endtask

    // Called at posedge+1: drive one cycle, queue the expectation, check after the edge.
    task automatic drive(input logic v, input logic st, input logic [31:0] pc,
                         input logic isbr, input logic jal, input logic jalr, input logic en,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input logic [31:0] ipc);
        exp_t        e;
        exp_t        got;
        logic        res, tk, mp;
        logic [31:0] t, act;
        ex_valid = v;   ex_stall = st;  ex_pc = pc;
        ex_is_br = isbr; ex_is_jal = jal; ex_is_jalr = jalr;
        br_en = en;     ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptgt;
        if_pc = ipc;
        #1;
        check_eq("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_bht[ipc[7:2]][1]});
        res = v & ~st & (isbr | jal | jalr) & ~m_rv;
        tk  = (jal | jalr) ? 1'b1 : en;
        t   = jalr ? {tgt[31:1], 1'b0} : tgt;
        act = tk ? t : pc + 32'd4;
        mp  = (tk != pt) | (tk & pt & (t != ptgt));
        e.rv  = res & mp;
        e.mis = res & tk & (t[1:0] != 2'b00);
        if (res && mp) m_pc = act;
        if (res) m_bc = m_bc + 32'd1;
        if (res && mp) m_mc = m_mc + 32'd1;
        e.pc = m_pc; e.bc = m_bc; e.mc = m_mc;
        if (res && isbr && !jal && !jalr) begin
            if (en && m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]] = m_bht[pc[7:2]] + 2'b01;
            if (!en && m_bht[pc[7:2]] != 2'b00) m_bht[pc[7:2]] = m_bht[pc[7:2]] - 2'b01;
        end
        m_rv = e.rv;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check_eq("redirect_valid", {31'd0, redirect_valid}, {31'd0, got.rv});
            check_eq("flush", {31'd0, flush}, {31'd0, got.rv});
            check_eq("redirect_pc", redirect_pc, got.pc);
            check_eq("misalign", {31'd0, misalign}, {31'd0, got.mis});
            check_eq("branch_count", branch_count, got.bc);
            check_eq("mispredict_count", mispredict_count, got.mc);
        end
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, ipc);
    endtask

    // Resolve one instruction and let any redirect shadow drain.
    task automatic br(input logic [31:0] pc, input logic isbr, input logic jal, input logic jalr,
                      input logic en, input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        drive(1'b1, 1'b0, pc, isbr, jal, jalr, en, tgt, pt, ptgt, pc);
        if (m_rv) idle(pc);
    endtask

    initial begin
        logic [31:0] pc, tgt, ptgt;
        logic        isbr, jal, jalr, pt;
        int          kind;

        rst = 1'b1;
        ex_valid = 0; ex_stall = 0; ex_pc = 0; ex_is_br = 0; ex_is_jal = 0; ex_is_jalr = 0;
        br_en = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0; if_pc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        if_pc = 32'h0;
        #1 check_eq("reset_pred_0x0", {31'd0, if_pred_taken}, 32'd0);
        if_pc = 32'hFC;
        #1 check_eq("reset_pred_0xFC", {31'd0, if_pred_taken}, 32'd0);
        check_eq("reset_branch_count", branch_count, 32'd0);
        check_eq("reset_mispredict_count", mispredict_count, 32'd0);
        check_eq("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check_eq("reset_redirect_pc", redirect_pc, 32'd0);
        @(posedge clk);
        #1;

        // Taken BEQ predicted not-taken: redirect to 0x140, entry 0 goes 01->10.
        drive(1, 0, 32'h100, 1, 0, 0, 1, 32'h140, 0, 32'h0, 32'h100);
        check_eq("beq_redirect_pc", redirect_pc, 32'h140);
        idle(32'h100);
        check_eq("bht0_now_taken", {31'd0, if_pred_taken}, 32'd1);

        // Four not-taken resolutions saturate entry 0 at 00.
        for (int i = 0; i < 4; i++)
            br(32'h100, 1, 0, 0, 0, 32'h140, m_bht[0][1], 32'h140);
        check_eq("bht0_saturated", {30'd0, m_bht[0]}, 32'd0);
        idle(32'h100);

        // JALR with odd target: bit0 cleared, correct prediction, misaligned.
        drive(1, 0, 32'h204, 0, 0, 1, 0, 32'h203, 1, 32'h202, 32'h204);
        check_eq("jalr_misalign", {31'd0, misalign}, 32'd1);
        idle(32'h204);
        check_eq("jalr_misalign_drop", {31'd0, misalign}, 32'd0);

        // Mispredict followed immediately by a wrong-path branch in EX.
        drive(1, 0, 32'h300, 1, 0, 0, 1, 32'h380, 0, 32'h0, 32'h300);
        drive(1, 0, 32'h308, 1, 0, 0, 1, 32'h400, 0, 32'h0, 32'h308);
        idle(32'h308);

        // Pending pulse completes while EX is stalled; stalled branch does nothing.
        drive(1, 0, 32'h320, 1, 0, 0, 1, 32'h3A0, 0, 32'h0, 32'h320);
        drive(1, 1, 32'h324, 1, 0, 0, 1, 32'h3B0, 0, 32'h0, 32'h324);
        drive(1, 1, 32'h324, 0, 1, 0, 0, 32'h3C0, 0, 32'h0, 32'h324);
        idle(32'h324);

        // JAL with branch flag also set: jump wins, no BHT update.
        br(32'h40C, 1, 1, 0, 0, 32'h500, 0, 32'h0);
        br(32'h40C, 1, 1, 0, 0, 32'h500, 1, 32'h500);
        br(32'h40C, 1, 1, 0, 0, 32'h500, 1, 32'h504);

        // Train entry 5 strongly taken so the final reset has something to clear.
        br(32'h14, 1, 0, 0, 1, 32'h80, 0, 32'h0);
        br(32'h14, 1, 0, 0, 1, 32'h80, 1, 32'h80);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            isbr = (kind < 7) || (kind == 9);
            jal  = (kind == 7) || (kind == 9);
            jalr = (kind == 8);
            pc   = {$urandom_range(0, 3) == 0 ? $urandom() : 32'h0000_1000, 2'b00} |
                   {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            pc[1:0] = 2'b00;
            tgt  = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            pt   = ($urandom_range(0, 3) == 0) ? 1'($urandom()) : m_bht[pc[7:2]][1];
            ptgt = ($urandom_range(0, 3) == 0) ? $urandom() : (jalr ? {tgt[31:1], 1'b0} : tgt);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, pc, isbr, jal, jalr,
                  1'($urandom()), tgt, pt, ptgt, {24'd0, 6'($urandom_range(0, 63)), 2'b00});
        end
        idle(32'h0);

        // BNE at the top of memory, mispredicted taken: fall-through wraps to 0.
        drive(1, 0, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'h10, 1, 32'h10, 32'h14);
        check_eq("wrap_redirect_pc", redirect_pc, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check_eq("rst_mid_flush", {31'd0, flush}, 32'd0);
        check_eq("rst_mid_misalign", {31'd0, misalign}, 32'd0);
        check_eq("rst_mid_redirect_pc", redirect_pc, 32'd0);
        check_eq("rst_mid_branch_count", branch_count, 32'd0);
        check_eq("rst_mid_mispredict_count", mispredict_count, 32'd0);
        for (int i = 0; i < 64; i++) begin
            if_pc = i << 2;
            #1 check_eq("rst_bht_entry", {31'd0, if_pred_taken}, 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        br(32'h14, 1, 0, 0, 1, 32'h80, 0, 32'h0);
        idle(32'h14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
